// File: rtl/acondicionador_pkg.sv
// Shared types and helpers for the sensor/pushbutton input conditioner.
package acondicionador_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Width of a counter that must reach cycles-1.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Generic multi-flop synchroniser for asynchronous inputs; reset loads RESET_VAL.
module sincronizador #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) chain[i] <= RESET_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/acondicionador_entradas.sv
// Input conditioner: synchronises and debounces sensor switches and the accumulate
// button, emitting one enable pulse per press only while the sensor vector is one-hot.
module acondicionador_entradas
  import acondicionador_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic [3:0] sensores_raw,
  output logic [3:0] sensores,
  output logic       sensores_valid,
  output logic       enable,
  output logic       btn_rejected,
  output logic       btn_level
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic       btn_sync;
  logic [3:0] sens_sync;
  logic       btn_pressed_c;

  sincronizador #(
    .WIDTH    (1),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'(BTN_ACTIVE_LOW))
  ) u_sync_btn (
    .clk  (clk),
    .rst_n(reset),
    .d    (btn_raw),
    .q    (btn_sync)
  );

  sincronizador #(
    .WIDTH    (4),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(4'b0000)
  ) u_sync_sens (
    .clk  (clk),
    .rst_n(reset),
    .d    (sensores_raw),
    .q    (sens_sync)
  );

  // Internal pressed level is always active-high.
  assign btn_pressed_c = btn_sync ^ BTN_ACTIVE_LOW;

  // Sensor debouncer: one saturating counter for the whole vector.
  logic [3:0]    sens_cand;
  logic [CW-1:0] sens_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sens_cand      <= 4'b0000;
      sens_cnt       <= '0;
      sensores       <= 4'b0000;
      sensores_valid <= 1'b0;
    end else if (sens_sync != sens_cand) begin
      sens_cand <= sens_sync;
      sens_cnt  <= '0;
    end else if (sens_cnt == CNT_MAX) begin
      sensores       <= sens_cand;
      sensores_valid <= $onehot(sens_cand);
    end else begin
      sens_cnt <= sens_cnt + CW'(1);
    end
  end

  // Button FSM: state register.
  btn_state_t    state_q, state_nxt;
  logic [CW-1:0] bcnt_q, bcnt_nxt;
  logic          confirm_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_nxt;
      bcnt_q  <= bcnt_nxt;
    end
  end

  // Button FSM: next state and debounce count.
  always_comb begin
    state_nxt = state_q;
    bcnt_nxt  = bcnt_q;
    confirm_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_pressed_c) begin
          state_nxt = PRESS_WAIT;
          bcnt_nxt  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_pressed_c) begin
          state_nxt = IDLE;
        end else if (bcnt_q == CNT_MAX) begin
          state_nxt = PRESSED;
          confirm_c = 1'b1;
        end else begin
          bcnt_nxt = bcnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!btn_pressed_c) begin
          state_nxt = RELEASE_WAIT;
          bcnt_nxt  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_pressed_c) begin
          state_nxt = PRESSED;
        end else if (bcnt_q == CNT_MAX) begin
          state_nxt = IDLE;
        end else begin
          bcnt_nxt = bcnt_q + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Button FSM: outputs. The gate sees the sensores_valid currently registered,
  // so a simultaneous sensor update cannot influence this press.
  logic enable_nxt, rejected_nxt, level_nxt;

  always_comb begin
    enable_nxt   = 1'b0;
    rejected_nxt = 1'b0;
    level_nxt    = 1'b0;
    if (confirm_c) begin
      enable_nxt   = sensores_valid;
      rejected_nxt = !sensores_valid;
    end
    level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable       <= 1'b0;
      btn_rejected <= 1'b0;
      btn_level    <= 1'b0;
    end else begin
      enable       <= enable_nxt;
      btn_rejected <= rejected_nxt;
      btn_level    <= level_nxt;
    end
  end

endmodule

// File: tb/tb_acondicionador_entradas.sv
// Scoreboard bench for acondicionador_entradas with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_acondicionador_entradas;

  localparam int LAT = 7;  // SYNC_STAGES + DEBOUNCE_CYCLES + 1

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_raw;
  logic [3:0] sensores_raw;
  logic [3:0] sensores;
  logic       sensores_valid;
  logic       enable;
  logic       btn_rejected;
  logic       btn_level;

  acondicionador_entradas #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .sensores_raw  (sensores_raw),
    .sensores      (sensores),
    .sensores_valid(sensores_valid),
    .enable        (enable),
    .btn_rejected  (btn_rejected),
    .btn_level     (btn_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         en;
    logic [3:0] sens;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pulse(input bit en, input logic [3:0] sens);
    exp_t e;
    e.en   = en;
    e.sens = sens;
    e.at   = cyc + LAT;
    sb.push_back(e);
  endtask

  // Press, hold for the given cycles, release, then let the FSM return to IDLE.
  task automatic press(input int hold, input bit en, input logic [3:0] sens);
    btn_raw = 1'b0;
    expect_pulse(en, sens);
    tick(hold);
    btn_raw = 1'b1;
    tick(10);
  endtask

  // Monitor: every enable/btn_rejected pulse must match the oldest expectation.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (enable || btn_rejected) begin
        chk("pulse_exclusive", 32'(enable & btn_rejected), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {30'd0, enable, btn_rejected}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pulse_enable", 32'(enable), 32'(e.en));
          chk("pulse_rejected", 32'(btn_rejected), 32'(!e.en));
          chk("pulse_sensores", 32'(sensores), 32'(e.sens));
          chk("pulse_cycle", 32'(cyc), 32'(e.at));
        end
      end
    end
  end

  initial begin
    reset        = 1'b0;
    btn_raw      = 1'b1;
    sensores_raw = 4'b0000;

    // 1. Reset held with toggling inputs: all outputs stay 0.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      btn_raw      = ~btn_raw;
      sensores_raw = 4'(i + 1);
      chk("reset_outputs", 32'({sensores, sensores_valid, enable, btn_rejected, btn_level}), 32'd0);
    end
    btn_raw      = 1'b1;
    sensores_raw = 4'b0000;
    tick(1);
    reset = 1'b1;
    tick(12);
    chk("idle_level", 32'(btn_level), 32'd0);
    chk("idle_sensores", 32'({sensores, sensores_valid}), 32'd0);

    // 2. Clean sensor change lands exactly LAT cycles later.
    sensores_raw = 4'b0100;
    tick(LAT - 1);
    chk("sens_before_lat", 32'(sensores), 32'h0);
    tick(1);
    chk("sens_at_lat", 32'(sensores), 32'h4);
    chk("valid_at_lat", 32'(sensores_valid), 32'd1);
    // Bounce 0001/0100/0001 restarts the count: update slips by 2 cycles.
    sensores_raw = 4'b0001;
    tick(1);
    sensores_raw = 4'b0100;
    tick(1);
    sensores_raw = 4'b0001;
    tick(LAT - 1);
    chk("bounce_held_off", 32'(sensores), 32'h4);
    tick(1);
    chk("bounce_update", 32'(sensores), 32'h1);

    // 3. Valid sensors, button held 50 cycles: one enable, btn_level timing.
    sensores_raw = 4'b0010;
    tick(LAT + 1);
    chk("sens_0010", 32'({sensores, sensores_valid}), 32'({4'b0010, 1'b1}));
    btn_raw = 1'b0;
    expect_pulse(1'b1, 4'b0010);
    tick(LAT - 1);
    chk("level_before_press", 32'(btn_level), 32'd0);
    tick(1);
    chk("level_pressed", 32'(btn_level), 32'd1);
    tick(50 - LAT);
    btn_raw = 1'b1;
    tick(LAT - 1);
    chk("level_release_wait", 32'(btn_level), 32'd1);
    tick(1);
    chk("level_released", 32'(btn_level), 32'd0);
    tick(5);

    // 4. Chatter 2 on / 2 off five times: no pulse of either kind.
    for (int i = 0; i < 5; i++) begin
      btn_raw = 1'b0;
      tick(2);
      btn_raw = 1'b1;
      tick(2);
    end
    tick(10);
    chk("chatter_level", 32'(btn_level), 32'd0);
    // Release bounce while PRESSED: no second pulse.
    btn_raw = 1'b0;
    expect_pulse(1'b1, 4'b0010);
    tick(10);
    btn_raw = 1'b1;
    tick(2);
    btn_raw = 1'b0;
    tick(4);
    chk("bounce_still_pressed", 32'(btn_level), 32'd1);
    tick(4);
    btn_raw = 1'b1;
    tick(10);

    // 5. Multi-hot and all-zero sensors: each press rejected.
    sensores_raw = 4'b0110;
    tick(LAT + 1);
    chk("multihot_valid", 32'({sensores, sensores_valid}), 32'({4'b0110, 1'b0}));
    press(10, 1'b0, 4'b0110);
    sensores_raw = 4'b0000;
    tick(LAT + 1);
    chk("zero_valid", 32'({sensores, sensores_valid}), 32'({4'b0000, 1'b0}));
    press(10, 1'b0, 4'b0000);

    // 6. Reset mid PRESS_WAIT, released while the button is still held.
    sensores_raw = 4'b0010;
    tick(LAT + 1);
    btn_raw = 1'b0;
    tick(4);
    reset = 1'b0;
    #1;
    chk("midpress_reset_outs", 32'({sensores, sensores_valid, enable, btn_rejected, btn_level}), 32'd0);
    tick(3);
    reset = 1'b1;
    // Held press re-debounces in lockstep with the sensors, so it is gated by the
    // reset-time sensores_valid=0 and shows up as a rejection, never an enable.
    expect_pulse(1'b0, 4'b0010);
    tick(LAT - 1);
    chk("post_reset_no_level", 32'(btn_level), 32'd0);
    tick(10);
    btn_raw = 1'b1;
    tick(10);
    press(10, 1'b1, 4'b0010);

    tick(5);
    done = 1'b1;
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
